// File: rtl/bomb_scheduler_if.sv
// Signal bundle between the player controllers / explosion engine and the bomb scheduler.
// The scheduler takes the slave view; whoever drives placements, ticks and chain hits takes the master view.
interface bomb_scheduler_if;
    logic         tick;
    logic         p1_put;
    logic [7:0]   p1_cor;
    logic [2:0]   p1_cap;
    logic [1:0]   p1_len;
    logic         p2_put;
    logic [7:0]   p2_cor;
    logic [2:0]   p2_cap;
    logic [1:0]   p2_len;
    logic         p1_acc;
    logic         p2_acc;
    logic         p1_rej;
    logic         p2_rej;
    logic [2:0]   bomb_num_p1;
    logic [2:0]   bomb_num_p2;
    logic [255:0] occ;
    logic         det_valid;
    logic         det_ready;
    logic [7:0]   det_cor;
    logic [1:0]   det_len;
    logic         det_owner;
    logic         chain_valid;
    logic [7:0]   chain_cor;

    modport master (
        output tick, p1_put, p1_cor, p1_cap, p1_len, p2_put, p2_cor, p2_cap, p2_len,
               det_ready, chain_valid, chain_cor,
        input  p1_acc, p2_acc, p1_rej, p2_rej, bomb_num_p1, bomb_num_p2, occ,
               det_valid, det_cor, det_len, det_owner
    );

    modport slave (
        input  tick, p1_put, p1_cor, p1_cap, p1_len, p2_put, p2_cor, p2_cap, p2_len,
               det_ready, chain_valid, chain_cor,
        output p1_acc, p2_acc, p1_rej, p2_rej, bomb_num_p1, bomb_num_p2, occ,
               det_valid, det_cor, det_len, det_owner
    );
endinterface

// File: rtl/bomb_scheduler.sv
// Shared bomb slot table: placement arbitration between two players, per-slot fuses,
// chain-reaction ripening and serialised detonation towards the explosion engine.
module bomb_scheduler #(
    parameter int NSLOTS = 8,
    parameter int FUSE   = 90,
    parameter int FUSE_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    bomb_scheduler_if.slave bus
);
    localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam logic [FUSE_W-1:0] FUSE_INIT = FUSE_W'(FUSE);
    localparam logic [FUSE_W-1:0] FUSE_ONE  = FUSE_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NSLOTS-1:0] w_valid;
    logic [NSLOTS-1:0] w_owner;
    logic [NSLOTS-1:0] w_ripe;
    logic [7:0]        w_cor [NSLOTS];
    logic [1:0]        w_len [NSLOTS];

    logic [255:0] r_occ;
    logic [2:0]   r_num_p1;
    logic [2:0]   r_num_p2;
    logic         r_rr;
    logic         r_p1_acc;
    logic         r_p1_rej;
    logic         r_p2_acc;
    logic         r_p2_rej;
    logic [SW-1:0] r_sel;
    logic [7:0]   r_det_cor;
    logic [1:0]   r_det_len;
    logic         r_det_owner;

    logic [SW-1:0] w_free0;
    logic [SW-1:0] w_free1;
    logic          w_has0;
    logic          w_has1;
    logic          w_ok1;
    logic          w_ok2;
    logic          w_same_cor;
    logic          w_grant1;
    logic          w_grant2;
    logic [SW-1:0] w_slot1;
    logic [SW-1:0] w_slot2;
    logic          w_rr_next;
    logic          w_any_ripe;
    logic [SW-1:0] w_ripe_idx;
    logic          w_load;
    logic          w_release;
    logic          w_dec1;
    logic          w_dec2;

    // Lowest and second-lowest free slot; only slots already free at the start of the cycle count.
    always_comb begin
        w_free0 = '0;
        w_free1 = '0;
        w_has0  = 1'b0;
        w_has1  = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (!w_valid[i]) begin
                if (!w_has0) begin
                    w_free0 = SW'(i);
                    w_has0  = 1'b1;
                end else if (!w_has1) begin
                    w_free1 = SW'(i);
                    w_has1  = 1'b1;
                end
            end
        end
    end

    // occ is looked at before this cycle's release, so a tile being freed right now still rejects.
    assign w_ok1      = bus.p1_put && (r_num_p1 < bus.p1_cap) && !r_occ[bus.p1_cor];
    assign w_ok2      = bus.p2_put && (r_num_p2 < bus.p2_cap) && !r_occ[bus.p2_cor];
    assign w_same_cor = (bus.p1_cor == bus.p2_cor);

    always_comb begin
        w_grant1  = 1'b0;
        w_grant2  = 1'b0;
        w_slot1   = w_free0;
        w_slot2   = w_free0;
        w_rr_next = r_rr;
        if (w_ok1 && w_ok2) begin
            if (w_has1 && !w_same_cor) begin
                w_grant1 = 1'b1;
                w_grant2 = 1'b1;
                w_slot1  = r_rr ? w_free1 : w_free0;
                w_slot2  = r_rr ? w_free0 : w_free1;
            end else if (w_has0) begin
                w_grant1  = !r_rr;
                w_grant2  = r_rr;
                w_rr_next = !r_rr;
            end
        end else begin
            w_grant1 = w_ok1 && w_has0;
            w_grant2 = w_ok2 && w_has0;
        end
    end

    always_comb begin
        w_any_ripe = 1'b0;
        w_ripe_idx = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (w_ripe[i]) begin
                w_any_ripe = 1'b1;
                w_ripe_idx = SW'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_ripe) begin
                    w_load       = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.det_ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
            logic              r_valid;
            logic              r_owner;
            logic              r_ripe;
            logic [7:0]        r_cor;
            logic [1:0]        r_len;
            logic [FUSE_W-1:0] r_fuse;
            logic              w_alloc1;
            logic              w_alloc2;
            logic              w_rel;
            logic              w_in_send;
            logic              w_chain_hit;
            logic              w_dec;

            assign w_alloc1    = w_grant1 && (w_slot1 == SW'(gi));
            assign w_alloc2    = w_grant2 && (w_slot2 == SW'(gi));
            assign w_in_send   = (r_state == S_SEND) && (r_sel == SW'(gi));
            assign w_rel       = w_release && (r_sel == SW'(gi));
            assign w_chain_hit = bus.chain_valid && r_valid && !r_ripe && !w_in_send
                                 && (r_cor == bus.chain_cor);
            assign w_dec       = bus.tick && r_valid && !r_ripe && (r_fuse != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_owner <= 1'b0;
                    r_ripe  <= 1'b0;
                    r_cor   <= '0;
                    r_len   <= '0;
                    r_fuse  <= '0;
                end else if (w_alloc1 || w_alloc2) begin
                    r_valid <= 1'b1;
                    r_owner <= w_alloc2;
                    r_ripe  <= 1'b0;
                    r_cor   <= w_alloc2 ? bus.p2_cor : bus.p1_cor;
                    r_len   <= w_alloc2 ? bus.p2_len : bus.p1_len;
                    r_fuse  <= FUSE_INIT;
                end else if (w_rel) begin
                    r_valid <= 1'b0;
                    r_ripe  <= 1'b0;
                end else begin
                    if (w_dec) begin
                        r_fuse <= r_fuse - FUSE_ONE;
                        if (r_fuse == FUSE_ONE) begin
                            r_ripe <= 1'b1;
                        end
                    end
                    if (w_chain_hit) begin
                        r_ripe <= 1'b1;
                    end
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_owner[gi] = r_owner;
            assign w_ripe[gi]  = r_ripe;
            assign w_cor[gi]   = r_cor;
            assign w_len[gi]   = r_len;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_det_cor   <= '0;
            r_det_len   <= '0;
            r_det_owner <= 1'b0;
        end else if (w_load) begin
            r_sel       <= w_ripe_idx;
            r_det_cor   <= w_cor[w_ripe_idx];
            r_det_len   <= w_len[w_ripe_idx];
            r_det_owner <= w_owner[w_ripe_idx];
        end
    end

    // A placement and a release can never touch the same tile, since occupied tiles are rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            if (w_release) begin
                r_occ[r_det_cor] <= 1'b0;
            end
            if (w_grant1) begin
                r_occ[bus.p1_cor] <= 1'b1;
            end
            if (w_grant2) begin
                r_occ[bus.p2_cor] <= 1'b1;
            end
        end
    end

    assign w_dec1 = w_release && !r_det_owner && (r_num_p1 != 3'd0);
    assign w_dec2 = w_release &&  r_det_owner && (r_num_p2 != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_p1 <= '0;
            r_num_p2 <= '0;
            r_rr     <= 1'b0;
            r_p1_acc <= 1'b0;
            r_p1_rej <= 1'b0;
            r_p2_acc <= 1'b0;
            r_p2_rej <= 1'b0;
        end else begin
            if (w_grant1 && !w_dec1) begin
                r_num_p1 <= r_num_p1 + 3'd1;
            end else if (!w_grant1 && w_dec1) begin
                r_num_p1 <= r_num_p1 - 3'd1;
            end
            if (w_grant2 && !w_dec2) begin
                r_num_p2 <= r_num_p2 + 3'd1;
            end else if (!w_grant2 && w_dec2) begin
                r_num_p2 <= r_num_p2 - 3'd1;
            end
            r_rr     <= w_rr_next;
            r_p1_acc <= w_grant1;
            r_p1_rej <= bus.p1_put && !w_grant1;
            r_p2_acc <= w_grant2;
            r_p2_rej <= bus.p2_put && !w_grant2;
        end
    end

    assign bus.p1_acc      = r_p1_acc;
    assign bus.p1_rej      = r_p1_rej;
    assign bus.p2_acc      = r_p2_acc;
    assign bus.p2_rej      = r_p2_rej;
    assign bus.bomb_num_p1 = r_num_p1;
    assign bus.bomb_num_p2 = r_num_p2;
    assign bus.occ         = r_occ;
    assign bus.det_valid   = (r_state == S_SEND);
    assign bus.det_cor     = r_det_cor;
    assign bus.det_len     = r_det_len;
    assign bus.det_owner   = r_det_owner;
endmodule
